// File: rtl/saph_incr_sequencer.sv
// Job sequencer for saph_float_incrementer: accepts a job, latches the incrementer,
// issues steps in chunks of up to 3 with a one-cycle holdoff, then returns the final lane values.
module saph_incr_sequencer #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned STEP_W = 16,
  parameter int unsigned FW     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [LANES-1:0][FW-1:0]   job_init,
  input  logic [LANES-1:0][FW-1:0]   job_inc,
  input  logic [STEP_W-1:0]          job_steps,
  output logic                       inc_latch,
  output logic [1:0]                 inc_count,
  input  logic                       inc_ready,
  output logic [LANES-1:0][FW-1:0]   inc_init,
  output logic [LANES-1:0][FW-1:0]   inc_inc,
  input  logic [LANES-1:0][FW-1:0]   inc_cur,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [LANES-1:0][FW-1:0]   res_data,
  output logic                       busy
);

  typedef enum logic [2:0] {IDLE, LATCH, ISSUE, DRAIN, RESULT} state_t;

  state_t              state, state_n;
  logic [STEP_W-1:0]   remaining, remaining_n;
  logic                holdoff, holdoff_n;
  logic                res_valid_n;
  logic                accept, capture;
  logic [1:0]          chunk;

  assign chunk = (remaining > STEP_W'(3)) ? 2'd3 : remaining[1:0];

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    holdoff_n   = holdoff;
    res_valid_n = res_valid;
    accept      = 1'b0;
    capture     = 1'b0;
    job_ready   = 1'b0;
    inc_latch   = 1'b0;
    inc_count   = 2'd0;
    unique case (state)
      IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          accept      = 1'b1;
          remaining_n = job_steps;
          state_n     = LATCH;
        end
      end
      LATCH: begin
        inc_latch = 1'b1;
        holdoff_n = 1'b1;
        state_n   = ISSUE;
      end
      ISSUE: begin
        // Only a zero-step job reaches ISSUE with remaining==0; the chunk that empties
        // remaining moves to DRAIN itself, carrying its holdoff along.
        if (remaining == '0) begin
          holdoff_n = 1'b0;
          state_n   = DRAIN;
        end else if (holdoff) begin
          holdoff_n = 1'b0;
        end else if (inc_ready) begin
          inc_count   = chunk;
          remaining_n = remaining - STEP_W'(chunk);
          holdoff_n   = 1'b1;
          if (remaining == STEP_W'(chunk)) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (holdoff) begin
          holdoff_n = 1'b0;
        end else if (inc_ready) begin
          capture     = 1'b1;
          res_valid_n = 1'b1;
          state_n     = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!rst) begin
      job_ready = 1'b0;
      inc_latch = 1'b0;
      inc_count = 2'd0;
    end
  end

  assign busy = rst && (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      holdoff   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      inc_init  <= '0;
      inc_inc   <= '0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      holdoff   <= holdoff_n;
      res_valid <= res_valid_n;
      if (accept) begin
        inc_init <= job_init;
        inc_inc  <= job_inc;
      end
      if (capture) res_data <= inc_cur;
    end
  end

endmodule

// File: tb/tb_saph_incr_sequencer.sv
// Directed + randomized bench for saph_incr_sequencer with a stand-in incrementer that
// treats lane values as fixed-point thousandths (1.010 -> 1010).
module tb_saph_incr_sequencer;
  localparam int unsigned LANES  = 2;
  localparam int unsigned STEP_W = 16;
  localparam int unsigned FW     = 32;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     job_valid = 1'b0;
  logic                     job_ready;
  logic [LANES-1:0][FW-1:0] job_init = '0;
  logic [LANES-1:0][FW-1:0] job_inc = '0;
  logic [STEP_W-1:0]        job_steps = '0;
  logic                     inc_latch;
  logic [1:0]               inc_count;
  logic                     inc_ready = 1'b1;
  logic [LANES-1:0][FW-1:0] inc_init;
  logic [LANES-1:0][FW-1:0] inc_inc;
  logic [LANES-1:0][FW-1:0] inc_cur = '0;
  logic                     res_valid;
  logic                     res_ready = 1'b0;
  logic [LANES-1:0][FW-1:0] res_data;
  logic                     busy;

  int tests = 0;
  int fails = 0;

  saph_incr_sequencer #(.LANES(LANES), .STEP_W(STEP_W), .FW(FW)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_init(job_init), .job_inc(job_inc), .job_steps(job_steps),
    .inc_latch(inc_latch), .inc_count(inc_count), .inc_ready(inc_ready),
    .inc_init(inc_init), .inc_inc(inc_inc), .inc_cur(inc_cur),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in incrementer: load on latch, otherwise add count*inc per lane.
  always_ff @(posedge clk) begin
    if (inc_latch) inc_cur <= inc_init;
    else
      for (int l = 0; l < int'(LANES); l++)
        inc_cur[l] <= inc_cur[l] + FW'(inc_count) * inc_inc[l];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: inc_ready always 1; 1: low for gap_len cycles from gap_start; 2: random.
  task automatic run_job(input logic [FW-1:0] i0, input logic [FW-1:0] i1,
                         input logic [FW-1:0] c0, input logic [FW-1:0] c1,
                         input int steps, input int mode, input int gap_start,
                         input int gap_len, input int res_hold, input bit timing);
    int cyc, issued, latches, nz, rem, exp_chunk, chunks;
    bit prev_block;
    logic [FW-1:0] e0, e1;
    e0 = i0 + FW'(steps) * c0;
    e1 = i1 + FW'(steps) * c1;
    @(negedge clk);
    job_init = {i1, i0}; job_inc = {c1, c0}; job_steps = STEP_W'(steps);
    job_valid = 1'b1; inc_ready = 1'b1; res_ready = 1'b0;
    #1 check("job_ready_idle", 64'(job_ready), 64'd1);
    @(negedge clk);
    job_valid = 1'b0;
    cyc = 1; issued = 0; latches = 0; nz = 0; prev_block = 1'b0;
    while (cyc < 400) begin
      case (mode)
        1:       inc_ready = !(cyc >= gap_start && cyc < gap_start + gap_len);
        2:       inc_ready = ($urandom % 4) != 0;
        default: inc_ready = 1'b1;
      endcase
      #1;
      if (inc_latch) begin
        latches++;
        check("latch_cycle", 64'(cyc), 64'd1);
      end
      if (inc_count != 2'd0) begin
        rem = steps - issued;
        exp_chunk = (rem > 3) ? 3 : rem;
        check("count_needs_ready", 64'(inc_ready), 64'd1);
        check("count_holdoff", 64'(prev_block), 64'd0);
        check("count_chunk", 64'(inc_count), 64'(exp_chunk));
        if (timing) check("count_cycle", 64'(cyc), 64'(3 + 2 * nz));
        issued += int'(inc_count);
        nz++;
      end
      prev_block = inc_latch || (inc_count != 2'd0);
      if (res_valid) break;
      check("job_ready_busy", 64'(job_ready), 64'd0);
      @(negedge clk);
      cyc++;
    end
    inc_ready = 1'b1;
    chunks = (steps + 2) / 3;
    check("res_valid_seen", 64'(res_valid), 64'd1);
    if (timing) check("res_valid_cycle", 64'(cyc), 64'(2 * chunks + 4));
    check("latch_once", 64'(latches), 64'd1);
    check("steps_total", 64'(issued), 64'(steps));
    check("res_lane0", 64'(res_data[0]), 64'(e0));
    check("res_lane1", 64'(res_data[1]), 64'(e1));
    for (int h = 0; h < res_hold; h++) begin
      @(negedge clk);
      job_valid = 1'b1;
      #1;
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_lane0", 64'(res_data[0]), 64'(e0));
      check("hold_lane1", 64'(res_data[1]), 64'(e1));
      check("hold_job_ready", 64'(job_ready), 64'd0);
    end
    @(negedge clk);
    job_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_job_ready", 64'(job_ready), 64'd1);
    check("idle_res_valid", 64'(res_valid), 64'd0);
  endtask

  initial begin
    // Reset with a job being offered
    rst = 1'b0; job_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_job_ready", 64'(job_ready), 64'd0);
      check("rst_inc_latch", 64'(inc_latch), 64'd0);
      check("rst_inc_count", 64'(inc_count), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
    end
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_inc_init", 64'(inc_init), 64'd0);
    check("rst_inc_inc", 64'(inc_inc), 64'd0);
    job_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("release_job_ready", 64'(job_ready), 64'd1);
    check("release_busy", 64'(busy), 64'd0);

    // Basic 5-step job, then zero-step job, then ready gap
    run_job(32'd1010, 32'd3141, 32'd125, 32'd1, 5, 0, 0, 0, 0, 1'b1);
    run_job(32'd1010, 32'd3141, 32'd125, 32'd1, 0, 0, 0, 0, 0, 1'b1);
    run_job(32'd500, 32'd7, 32'd10, 32'd3, 7, 1, 4, 4, 0, 1'b0);

    // Consumer stalls for 10 cycles in RESULT
    run_job(32'd20, 32'd40, 32'd2, 32'd4, 4, 0, 0, 0, 10, 1'b1);

    // Reset in the middle of a long job
    @(negedge clk);
    job_init = {32'd9, 32'd8}; job_inc = {32'd1, 32'd1}; job_steps = 16'd100;
    job_valid = 1'b1; inc_ready = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_count", 64'(inc_count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("postrst_count", 64'(inc_count), 64'd0);
    check("postrst_latch", 64'(inc_latch), 64'd0);
    check("postrst_busy", 64'(busy), 64'd0);
    check("postrst_res_valid", 64'(res_valid), 64'd0);
    run_job(32'd300, 32'd600, 32'd15, 32'd25, 2, 0, 0, 0, 0, 1'b1);

    // Random jobs against init + steps*inc
    for (int j = 0; j < 8; j++)
      run_job($urandom, $urandom, 32'($urandom_range(0, 5000)), 32'($urandom_range(0, 5000)),
              int'($urandom_range(0, 20)), 2, 0, 0, int'($urandom_range(0, 3)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
